// File: rtl/tri_debug_mux_cyc_pkg.sv
// Shared types and helpers for the tri-state-free debug trace mux family.
// Rotation encodings are shared with the legacy 16-way mux.
package tri_debug_mux_cyc_pkg;

    typedef enum logic [1:0] {
        ROT_NONE = 2'd0,
        ROT_3Q   = 2'd1,
        ROT_HALF = 2'd2,
        ROT_1Q   = 2'd3
    } rot_e;

    typedef enum logic {
        CYC_IDLE = 1'b0,
        CYC_RUN  = 1'b1
    } cyc_state_e;

    // Output quarter q takes source quarter (q - rot) mod 4; the 2-bit wrap is the modulo.
    function automatic logic [1:0] src_quarter(input logic [1:0] q, input rot_e rot);
        return q - rot;
    endfunction

endpackage

// File: rtl/tri_debug_rot_merge.sv
// Combinational quarter-word rotate followed by a per-quarter merge with the
// upstream trace bus. Quarter 0 is the most-significant quarter (bit 0 end).
module tri_debug_rot_merge
    import tri_debug_mux_cyc_pkg::*;
#(
    parameter int DBG_WIDTH = 32
) (
    input  logic [0:DBG_WIDTH-1] grp_data,
    input  logic [0:DBG_WIDTH-1] trace_data_in,
    input  logic [0:1]           rot_sel,
    input  logic [0:3]           lane_en,
    output logic [0:DBG_WIDTH-1] merged
);

    localparam int Q = DBG_WIDTH / 4;

    rot_e rot_amt;
    assign rot_amt = rot_e'(rot_sel);

    always_comb begin
        // NOTE: a default on every path keeps always_comb from inferring latches.
        merged = '0;
        for (int q = 0; q < 4; q++) begin
            if (lane_en[q]) begin
                merged[q*Q +: Q] = grp_data[src_quarter(2'(q), rot_amt)*Q +: Q];
            end else begin
                merged[q*Q +: Q] = trace_data_in[q*Q +: Q];
            end
        end
    end

endmodule

// File: rtl/tri_debug_mux_cyc.sv
// Registered debug-group trace mux with auto-cycle over a group range and a
// global hold. Each instance is one pipeline stage of the trace daisy chain.
module tri_debug_mux_cyc
    import tri_debug_mux_cyc_pkg::*;
#(
    parameter int DBG_WIDTH  = 32,
    parameter int NUM_GROUPS = 16,
    parameter int SEL_W      = 4,
    parameter int DWELL_W    = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [0:SEL_W-1]               grp_sel,
    input  logic [0:SEL_W-1]               cycle_last,
    input  logic                           cycle_en,
    input  logic [0:DWELL_W-1]             dwell,
    input  logic [0:1]                     rot_sel,
    input  logic [0:3]                     lane_en,
    input  logic                           trace_hold,
    input  logic [0:NUM_GROUPS*DBG_WIDTH-1] dbg_groups,
    input  logic [0:DBG_WIDTH-1]           trace_data_in,
    input  logic [0:3]                     coretrace_ctrls_in,
    output logic [0:DBG_WIDTH-1]           trace_data_out,
    output logic [0:3]                     coretrace_ctrls_out,
    output logic [0:SEL_W-1]               trace_grp_id
);

    if (DBG_WIDTH % 4 != 0) begin : g_chk_width
        $error("tri_debug_mux_cyc: DBG_WIDTH must be a multiple of 4");
    end
    if (NUM_GROUPS != (1 << SEL_W)) begin : g_chk_groups
        $error("tri_debug_mux_cyc: NUM_GROUPS must equal 2**SEL_W");
    end

    logic [0:DBG_WIDTH-1] grp_data;
    logic [0:DBG_WIDTH-1] merged;
    logic [0:SEL_W-1]     cur_grp, cur_grp_nxt;
    logic [0:DWELL_W-1]   dwell_cnt, dwell_cnt_nxt;
    cyc_state_e           cyc_state, cyc_state_nxt;

    assign grp_data = dbg_groups[cur_grp*DBG_WIDTH +: DBG_WIDTH];

    tri_debug_rot_merge #(
        .DBG_WIDTH(DBG_WIDTH)
    ) u_rot_merge (
        .grp_data      (grp_data),
        .trace_data_in (trace_data_in),
        .rot_sel       (rot_sel),
        .lane_en       (lane_en),
        .merged        (merged)
    );

    // Priority: hold, then cycle_en low (beats dwell expiry), then entry, then stepping.
    always_comb begin
        cur_grp_nxt   = cur_grp;
        dwell_cnt_nxt = dwell_cnt;
        cyc_state_nxt = cyc_state;
        if (!trace_hold) begin
            if (!cycle_en) begin
                cyc_state_nxt = CYC_IDLE;
                cur_grp_nxt   = grp_sel;
                dwell_cnt_nxt = '0;
            end else if (cyc_state == CYC_IDLE) begin
                cyc_state_nxt = CYC_RUN;
                cur_grp_nxt   = grp_sel;
                dwell_cnt_nxt = '0;
            end else if (dwell_cnt == dwell) begin
                dwell_cnt_nxt = '0;
                // >= also covers an empty range (cycle_last < grp_sel) and the top-group wrap.
                cur_grp_nxt   = (cur_grp >= cycle_last) ? grp_sel : cur_grp + SEL_W'(1);
            end else begin
                dwell_cnt_nxt = dwell_cnt + DWELL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_state <= CYC_IDLE;
            cur_grp   <= '0;
            dwell_cnt <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            cyc_state <= cyc_state_nxt;
            cur_grp   <= cur_grp_nxt;
            dwell_cnt <= dwell_cnt_nxt;
        end
    end

    // trace_grp_id is taken from the same cur_grp that selected the data, keeping them coherent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trace_data_out      <= '0;
            coretrace_ctrls_out <= '0;
            trace_grp_id        <= '0;
        end else if (!trace_hold) begin
            trace_data_out      <= merged;
            coretrace_ctrls_out <= coretrace_ctrls_in;
            trace_grp_id        <= cur_grp;
        end
    end

endmodule

// File: tb/tb_tri_debug_mux_cyc.sv
// Randomized self-checking bench for tri_debug_mux_cyc against a schedule-based
// reference model (group index derived from elapsed cycles since cycle entry).
module tb_tri_debug_mux_cyc;

    localparam int W  = 32;
    localparam int NG = 16;
    localparam int SW = 4;
    localparam int DW = 8;
    localparam int Q  = W / 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [0:SW-1]     grp_sel, cycle_last;
    logic              cycle_en;
    logic [0:DW-1]     dwell;
    logic [0:1]        rot_sel;
    logic [0:3]        lane_en;
    logic              trace_hold;
    logic [0:NG*W-1]   dbg_groups;
    logic [0:W-1]      trace_data_in;
    logic [0:3]        ctrls_in;
    logic [0:W-1]      trace_data_out;
    logic [0:3]        ctrls_out;
    logic [0:SW-1]     trace_grp_id;

    logic [W-1:0]      grp_words [NG];

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [W-1:0]  exp_data;
    logic [3:0]    exp_ctrl;
    logic [SW-1:0] exp_id;
    int            m_cur, m_k, m_s, m_l, m_d;
    bit            m_in_cyc;

    for (genvar g = 0; g < NG; g++) begin : g_pack
        assign dbg_groups[g*W +: W] = grp_words[g];
    end

    tri_debug_mux_cyc #(
        .DBG_WIDTH(W), .NUM_GROUPS(NG), .SEL_W(SW), .DWELL_W(DW)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .grp_sel             (grp_sel),
        .cycle_last          (cycle_last),
        .cycle_en            (cycle_en),
        .dwell               (dwell),
        .rot_sel             (rot_sel),
        .lane_en             (lane_en),
        .trace_hold          (trace_hold),
        .dbg_groups          (dbg_groups),
        .trace_data_in       (trace_data_in),
        .coretrace_ctrls_in  (ctrls_in),
        .trace_data_out      (trace_data_out),
        .coretrace_ctrls_out (ctrls_out),
        .trace_grp_id        (trace_grp_id)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Rotate right by rot quarters numerically, then take group bits where lane is set.
    function automatic logic [W-1:0] model_word(logic [W-1:0] g, logic [W-1:0] tdi,
                                                int rot, logic [3:0] le);
        logic [2*W-1:0] dbl;
        logic [W-1:0]   r, mask;
        dbl  = {g, g} >> (rot * Q);
        r    = dbl[W-1:0];
        mask = '0;
        for (int i = 0; i < 4; i++) if (le[i]) mask[i*Q +: Q] = '1;
        return (r & mask) | (tdi & ~mask);
    endfunction

    // Group active k cycles after entry: each range member lasts dwell+1 cycles.
    function automatic int sched(int k);
        int len;
        len = (m_l >= m_s) ? (m_l - m_s + 1) : 1;
        return m_s + (k / (m_d + 1)) % len;
    endfunction

    task automatic model_reset();
        exp_data = '0; exp_ctrl = '0; exp_id = '0;
        m_cur = 0; m_k = 0; m_in_cyc = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n && !trace_hold) begin
            exp_data = model_word(grp_words[m_cur], trace_data_in, int'(rot_sel), lane_en);
            exp_ctrl = ctrls_in;
            exp_id   = m_cur[SW-1:0];
            if (!cycle_en) begin
                m_in_cyc = 1'b0;
                m_cur    = int'(grp_sel);
            end else if (!m_in_cyc) begin
                m_in_cyc = 1'b1;
                m_k = 0;
                m_s = int'(grp_sel); m_l = int'(cycle_last); m_d = int'(dwell);
                m_cur = m_s;
            end else begin
                m_k++;
                m_cur = sched(m_k);
            end
        end
        @(negedge clk);
    endtask

    task automatic rand_data();
        trace_data_in = $urandom;
        ctrls_in      = 4'($urandom);
        rot_sel       = 2'($urandom);
        lane_en       = 4'($urandom);
        grp_words[$urandom_range(0, NG-1)] = $urandom;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({trace_data_out, ctrls_out, trace_grp_id} !== '0) begin
            bad++;
            $display("FAIL reset: got data=%h ctl=%h id=%0d, want all zero",
                     trace_data_out, ctrls_out, trace_grp_id);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_static();
        for (int g = 0; g < NG; g++) grp_words[g] = {8{g[3:0]}};
        grp_sel = 5; rot_sel = 0; lane_en = 4'b1111; cycle_en = 0;
        tick();
        tick();
        total++;
        if (trace_data_out !== 32'h55555555 || trace_grp_id !== 4'd5) begin
            bad++;
            $display("FAIL static_latency: got data=%h id=%0d, want data=55555555 id=5",
                     trace_data_out, trace_grp_id);
        end
        for (int i = 0; i < 40; i++) begin
            rand_data();
            grp_sel = 4'($urandom);
            tick();
            total++;
            if ({trace_data_out, ctrls_out, trace_grp_id} !== {exp_data, exp_ctrl, exp_id}) begin
                bad++;
                $display("FAIL static_rand %0d: got data=%h ctl=%h id=%0d, want data=%h ctl=%h id=%0d",
                         i, trace_data_out, ctrls_out, trace_grp_id, exp_data, exp_ctrl, exp_id);
            end
        end
    endtask

    task automatic test_rotation();
        logic [W-1:0] want [4] = '{32'h22334411, 32'h44112233, 32'h22AA44AA, 32'h33441122};
        logic [1:0]   rots [4] = '{2'd3, 2'd1, 2'd3, 2'd2};
        logic [3:0]   lanes[4] = '{4'b1111, 4'b1111, 4'b1010, 4'b1111};
        grp_sel = 5; lane_en = 4'b1111; trace_data_in = 32'hAAAAAAAA;
        tick();
        tick();
        grp_words[5] = 32'h11223344;
        for (int i = 0; i < 4; i++) begin
            rot_sel = rots[i]; lane_en = lanes[i];
            tick();
            total++;
            if (trace_data_out !== want[i]) begin
                bad++;
                $display("FAIL rotation %0d: got %h, want %h", i, trace_data_out, want[i]);
            end
        end
    endtask

    task automatic test_cycling();
        int seq [13] = '{2, 2, 2, 3, 3, 3, 4, 4, 4, 2, 2, 2, 3};
        rot_sel = 0; lane_en = 4'b1111;
        grp_sel = 2; cycle_last = 4; dwell = 2; cycle_en = 0;
        tick();
        tick();
        cycle_en = 1;
        tick();
        for (int i = 0; i < 13; i++) begin
            tick();
            total++;
            if (int'(trace_grp_id) != seq[i] || trace_data_out !== grp_words[seq[i]]) begin
                bad++;
                $display("FAIL cycling step %0d: got id=%0d data=%h, want id=%0d data=%h",
                         i, trace_grp_id, trace_data_out, seq[i], grp_words[seq[i]]);
            end
        end
        cycle_en = 0;
        tick();
    endtask

    task automatic run_model(string name, int n);
        for (int i = 0; i < n; i++) begin
            rand_data();
            tick();
            total++;
            if ({trace_data_out, ctrls_out, trace_grp_id} !== {exp_data, exp_ctrl, exp_id}) begin
                bad++;
                $display("FAIL %s %0d: got data=%h ctl=%h id=%0d, want data=%h ctl=%h id=%0d",
                         name, i, trace_data_out, ctrls_out, trace_grp_id, exp_data, exp_ctrl, exp_id);
            end
        end
    endtask

    task automatic test_boundaries();
        grp_sel = 13; cycle_last = 15; dwell = 1; cycle_en = 1;
        run_model("wrap", 16);
        cycle_en = 0;
        tick();
        grp_sel = 3; cycle_last = 1; dwell = 0; cycle_en = 1;
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if (trace_grp_id !== 4'd3) begin
                bad++;
                $display("FAIL park %0d: got id=%0d, want 3", i, trace_grp_id);
            end
        end
        cycle_en = 0;
        tick();
        grp_sel = 0; cycle_last = 3; dwell = 0; cycle_en = 1;
        run_model("dwell0", 12);
        cycle_en = 0;
        tick();
    endtask

    task automatic test_hold();
        grp_sel = 6; cycle_last = 9; dwell = 3; cycle_en = 1;
        run_model("pre_hold", 6);
        trace_hold = 1;
        run_model("hold", 5);
        trace_hold = 0;
        run_model("post_hold", 10);
        cycle_en = 0;
        tick();
        trace_hold = 1;
        cycle_en = 1;
        run_model("rise_in_hold", 3);
        trace_hold = 0;
        run_model("rise_release", 8);
    endtask

    task automatic test_disable();
        int guard;
        cycle_en = 0;
        tick();
        grp_sel = 1; cycle_last = 5; dwell = 2; cycle_en = 1;
        run_model("pre_disable", 4);
        guard = 0;
        while (!(m_in_cyc && ((m_k + 1) % (m_d + 1) == 0)) && guard < 20) begin
            tick();
            guard++;
        end
        total++;
        if (guard >= 20) begin
            bad++;
            $display("FAIL disable_sync: expiry point not reached within 20 cycles");
        end
        cycle_en = 0; grp_sel = 11;
        tick();
        tick();
        total++;
        if (trace_grp_id !== 4'd11 || exp_id !== 4'd11) begin
            bad++;
            $display("FAIL disable_at_expiry: got id=%0d, want 11", trace_grp_id);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_data();
            trace_hold = ($urandom_range(0, 7) == 0);
            if (!cycle_en) begin
                grp_sel    = 4'($urandom);
                cycle_last = 4'($urandom);
                dwell      = 8'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 19) == 0) cycle_en = ~cycle_en;
            tick();
            total++;
            if ({trace_data_out, ctrls_out, trace_grp_id} !== {exp_data, exp_ctrl, exp_id}) begin
                bad++;
                $display("FAIL random %0d: got data=%h ctl=%h id=%0d, want data=%h ctl=%h id=%0d",
                         i, trace_data_out, ctrls_out, trace_grp_id, exp_data, exp_ctrl, exp_id);
            end
        end
        trace_hold = 0;
    endtask

    task automatic test_async_reset();
        cycle_en = 0;
        tick();
        grp_sel = 4; cycle_last = 7; dwell = 3; cycle_en = 1;
        run_model("pre_reset", 6);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({trace_data_out, ctrls_out, trace_grp_id} !== '0) begin
            bad++;
            $display("FAIL async_reset: got data=%h ctl=%h id=%0d, want all zero",
                     trace_data_out, ctrls_out, trace_grp_id);
        end
        model_reset();
        #1;
        rst_n = 1'b1;
        run_model("post_reset", 12);
    endtask

    initial begin
        grp_sel = 0; cycle_last = 0; cycle_en = 0; dwell = 0;
        rot_sel = 0; lane_en = 4'b1111; trace_hold = 0;
        trace_data_in = '0; ctrls_in = '0;
        for (int g = 0; g < NG; g++) grp_words[g] = '0;
        test_reset();
        test_static();
        test_rotation();
        test_cycling();
        test_boundaries();
        test_hold();
        test_disable();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
